pipeline_stage_reg: RTL and testbench
=====================================

PIPELINE_STAGE_REG -- requirements
Module: pipeline_stage_reg

Interface
REQ-001 The block SHALL have parameter CTRL_W, default 7, the width of the control bundle, which is zeroed on bubbles.
REQ-002 The block SHALL have parameter DATA_W, default 101, the width of the data bundle, which is never zeroed by a flush.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset: clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 ValidIn  in  1  upstream stage holds a valid instruction.
REQ-006 ReadyOut  out  1  this stage accepts ValidIn this cycle.
REQ-007 CtrlIn  in  CTRL_W  control bundle (e.g. RegWrite, ResultSrc, MemWrite, AddressingControl).
REQ-008 DataIn  in  DATA_W  data bundle (e.g. ALUResult, WriteData, Rd, PCPlus4).
REQ-009 Flush  in  1  synchronous kill of all held instructions.
REQ-010 ValidOut  out  1  output holds a valid instruction.
REQ-011 ReadyIn  in  1  downstream stage accepts ValidOut this cycle.
REQ-012 CtrlOut  out  CTRL_W  registered control; all-zero whenever ValidOut=0.
REQ-013 DataOut  out  DATA_W  registered data.
REQ-014 StallCount  out  16  saturating count of back-pressure cycles.

Function
REQ-015 Transfers: accept = ValidIn&ReadyOut; drain = ValidOut&ReadyIn; all state changes occur on the rising clk edge.
REQ-016 Latency: an accepted item SHALL appear on ValidOut/CtrlOut/DataOut exactly 1 cycle after acceptance when the stage is empty or draining.
REQ-017 Base mode (macro undefined): ReadyOut = ReadyIn | ~ValidOut (combinational); on accept, CtrlOut<=CtrlIn, DataOut<=DataIn, ValidOut<=1.
REQ-018 Base mode: on drain without accept, ValidOut<=0 and CtrlOut<=0; DataOut holds.
REQ-019 Hold: while ValidOut=1 and ReadyIn=0, all outputs SHALL be held stable.
REQ-020 Flush: when Flush=1, next cycle ValidOut=0, CtrlOut=0, and any skid entry is invalidated; DataOut holds.
REQ-021 Flush SHALL take priority over a simultaneous accept, and the accepted item is discarded.
REQ-022 StallCount SHALL increment when ValidOut=1 and ReadyIn=0 and Flush=0, SHALL saturate at 16'hFFFF, and SHALL never wrap.
REQ-023 Simultaneous accept and drain SHALL replace the output with the new item, with no bubble inserted (full throughput).

Reset
REQ-024 On rst=1, asynchronously: ValidOut=0, CtrlOut=0, DataOut=0, StallCount=0, skid entry invalid, state EMPTY.
REQ-025 Assertion of rst mid-stall or mid-transfer SHALL drop all held items; no partial update after rst deasserts.
REQ-026 ReadyOut SHALL be 1 in the first cycle after rst deasserts, in both configurations.

Configuration
REQ-027 Macro PIPE_STAGE_SKID_EN, when defined, SHALL add a one-entry skid buffer and make ReadyOut a registered signal (= ~skid valid), breaking the ReadyIn->ReadyOut combinational path.
REQ-028 With the skid buffer, states SHALL be EMPTY (no items), ONE (output only), and TWO (output+skid).
REQ-029 EMPTY->ONE on accept.
REQ-030 ONE->TWO on accept without drain; the item goes to the skid buffer.
REQ-031 ONE->EMPTY on drain without accept.
REQ-032 ONE->ONE on accept with drain, or on neither.
REQ-033 TWO->ONE on drain; the skid item moves to the output and ReadyOut rises in the next cycle.
REQ-034 From ONE or TWO, Flush SHALL force the next state to EMPTY.
REQ-035 Ordering SHALL be preserved: the skid item is always presented after the current output item.
REQ-036 Without the macro, the behaviour SHALL be exactly REQ-017..REQ-018, with no skid storage.

Verification
REQ-037 Reset then ValidIn=1, CtrlIn=7'h55, DataIn=1, ReadyIn=1 -> next cycle ValidOut=1, CtrlOut=7'h55, DataOut=1; StallCount=0.
REQ-038 Stream 8 items with ReadyIn=1 constant -> 8 consecutive ValidOut cycles, in order, with no gaps.
REQ-039 Hold item A with ReadyIn=0 for 5 cycles -> outputs stable at A, StallCount=5; base mode ReadyOut=0; skid mode accepts B, then ReadyOut=0 -> on release, A then B in order.
REQ-040 Flush=1 coincident with accept of CtrlIn=7'h7F -> next cycle ValidOut=0, CtrlOut=0, DataOut unchanged; the item never appears.
REQ-041 Force stall for 70000 cycles -> StallCount=16'hFFFF and held; assert rst mid-stall -> all outputs 0 immediately, ReadyOut=1 after release.

Source files
------------

// File: rtl/pipeline_stage_reg_if.sv
// Handshake bundle for pipeline_stage_reg: upstream valid/ready/ctrl/data, downstream
// valid/ready/ctrl/data, flush and the back-pressure counter. slave = the stage, master = its driver.
interface pipeline_stage_reg_if #(
    parameter int CTRL_W = 7,
    parameter int DATA_W = 101
);
    logic              ValidIn;
    logic              ReadyOut;
    logic [CTRL_W-1:0] CtrlIn;
    logic [DATA_W-1:0] DataIn;
    logic              Flush;
    logic              ValidOut;
    logic              ReadyIn;
    logic [CTRL_W-1:0] CtrlOut;
    logic [DATA_W-1:0] DataOut;
    logic [15:0]       StallCount;

    modport slave (
        input  ValidIn, CtrlIn, DataIn, Flush, ReadyIn,
        output ReadyOut, ValidOut, CtrlOut, DataOut, StallCount
    );

    modport master (
        output ValidIn, CtrlIn, DataIn, Flush, ReadyIn,
        input  ReadyOut, ValidOut, CtrlOut, DataOut, StallCount
    );
endinterface

// File: rtl/pipeline_stage_reg.sv
// Valid/ready pipeline register with flush, bubble-zeroed control and a saturating stall counter.
// Define PIPE_STAGE_SKID_EN for a one-entry skid buffer with a registered ReadyOut.
module pipeline_stage_reg #(
    parameter int CTRL_W = 7,
    parameter int DATA_W = 101
) (
    input  logic                clk,
    input  logic                rst,
    pipeline_stage_reg_if.slave bus
);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic              vld_p0;
    logic [CTRL_W-1:0] ctrl_p0;
    logic [DATA_W-1:0] data_p0;
    logic [15:0]       stall_cnt;
    logic              ready_out;
    logic              accept;
    logic              drain;
    logic              stall_en;

    assign accept   = bus.ValidIn & ready_out;
    assign drain    = vld_p0 & bus.ReadyIn;
    assign stall_en = vld_p0 & ~bus.ReadyIn & ~bus.Flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_en) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

`ifdef PIPE_STAGE_SKID_EN
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t            state, state_nxt;
    logic              rdy_q;
    logic              load_in, load_skid, load_from_skid, clr_out;
    logic [CTRL_W-1:0] ctrl_p1;
    logic [DATA_W-1:0] data_p1;

    assign ready_out = rdy_q;
    assign vld_p0    = (state != EMPTY);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            rdy_q <= 1'b1;
        end else begin
            state <= state_nxt;
            // Ready depends only on whether the skid slot will be occupied, never on ReadyIn.
            rdy_q <= (state_nxt != TWO);
        end
    end

    always_comb begin
        state_nxt      = state;
        load_in        = 1'b0;
        load_skid      = 1'b0;
        load_from_skid = 1'b0;
        clr_out        = 1'b0;
        if (bus.Flush) begin
            state_nxt = EMPTY;
            clr_out   = 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt = ONE;
                        load_in   = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        load_in = 1'b1;
                    end else if (accept) begin
                        state_nxt = TWO;
                        load_skid = 1'b1;
                    end else if (drain) begin
                        state_nxt = EMPTY;
                        clr_out   = 1'b1;
                    end
                end
                TWO: begin
                    if (drain) begin
                        state_nxt      = ONE;
                        load_from_skid = 1'b1;
                    end
                end
                default: begin
                    state_nxt = EMPTY;
                    clr_out   = 1'b1;
                end
            endcase
        end
    end

    // ---- stage p0: output register; stage p1: skid entry ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl_p0 <= '0;
            data_p0 <= '0;
            ctrl_p1 <= '0;
            data_p1 <= '0;
        end else begin
            if (load_in) begin
                ctrl_p0 <= bus.CtrlIn;
                data_p0 <= bus.DataIn;
            end else if (load_from_skid) begin
                ctrl_p0 <= ctrl_p1;
                data_p0 <= data_p1;
            end else if (clr_out) begin
                ctrl_p0 <= '0;
            end
            if (load_skid) begin
                ctrl_p1 <= bus.CtrlIn;
                data_p1 <= bus.DataIn;
            end
        end
    end
`else
    logic vld_q;

    assign vld_p0    = vld_q;
    assign ready_out = bus.ReadyIn | ~vld_q;

    // ---- stage p0: output register; data is left untouched by bubbles and flushes ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q   <= 1'b0;
            ctrl_p0 <= '0;
            data_p0 <= '0;
        end else if (bus.Flush) begin
            vld_q   <= 1'b0;
            ctrl_p0 <= '0;
        end else if (accept) begin
            vld_q   <= 1'b1;
            ctrl_p0 <= bus.CtrlIn;
            data_p0 <= bus.DataIn;
        end else if (drain) begin
            vld_q   <= 1'b0;
            ctrl_p0 <= '0;
        end
    end
`endif

    assign bus.ReadyOut   = ready_out;
    assign bus.ValidOut   = vld_p0;
    assign bus.CtrlOut    = ctrl_p0;
    assign bus.DataOut    = data_p0;
    assign bus.StallCount = stall_cnt;

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Scoreboard bench for pipeline_stage_reg; works with or without PIPE_STAGE_SKID_EN.
module tb_pipeline_stage_reg;
    localparam int CTRL_W = 7;
    localparam int DATA_W = 101;
    typedef logic [CTRL_W+DATA_W-1:0] item_t;

`ifdef PIPE_STAGE_SKID_EN
    localparam logic EXP_B_IN_SKID = 1'b1;
`else
    localparam logic EXP_B_IN_SKID = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipeline_stage_reg_if #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) bus ();
    pipeline_stage_reg #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int    errors = 0;
    int    checks = 0;
    item_t exp_q[$];
    item_t done_q[$];
    item_t obs_q[$];
    logic  last_acc;

    function automatic logic [DATA_W-1:0] rnd_data();
        return DATA_W'({$urandom, $urandom, $urandom, $urandom});
    endfunction

    task automatic drive(input logic [CTRL_W-1:0] c, input logic [DATA_W-1:0] d);
        bus.ValidIn = 1'b1;
        bus.CtrlIn  = c;
        bus.DataIn  = d;
    endtask

    // One clock: sample handshakes before the edge, keep the scoreboard, return at edge+1.
    task automatic step();
        logic acc, drn;
        #1;
        acc = bus.ValidIn & bus.ReadyOut;
        drn = bus.ValidOut & bus.ReadyIn;
        if (drn) begin
            obs_q.push_back({bus.CtrlOut, bus.DataOut});
            if (exp_q.size() > 0) done_q.push_back(exp_q.pop_front());
            else done_q.push_back('x);
        end
        if (bus.Flush) exp_q.delete();
        else if (acc) exp_q.push_back({bus.CtrlIn, bus.DataIn});
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        bus.ValidIn = 1'b0;
        bus.CtrlIn  = '0;
        bus.DataIn  = '0;
        bus.Flush   = 1'b0;
        bus.ReadyIn = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        done_q.delete();
        obs_q.delete();
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.ValidOut !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.ValidOut); end
        checks++; if (bus.CtrlOut !== '0) begin errors++; $display("FAIL reset_ctrl: got %h want 0", bus.CtrlOut); end
        checks++; if (bus.DataOut !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", bus.DataOut); end
        checks++; if (bus.StallCount !== 16'h0) begin errors++; $display("FAIL reset_stall: got %h want 0", bus.StallCount); end
        checks++; if (bus.ReadyOut !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", bus.ReadyOut); end
    endtask

    task automatic test_single();
        item_t o, e;
        do_reset();
        bus.ReadyIn = 1'b1;
        drive(7'h55, 101'd1);
        step();
        bus.ValidIn = 1'b0;
        checks++; if (bus.ValidOut !== 1'b1) begin errors++; $display("FAIL single_valid: got %b want 1", bus.ValidOut); end
        checks++; if (bus.CtrlOut !== 7'h55) begin errors++; $display("FAIL single_ctrl: got %h want 55", bus.CtrlOut); end
        checks++; if (bus.DataOut !== 101'd1) begin errors++; $display("FAIL single_data: got %h want 1", bus.DataOut); end
        checks++; if (bus.StallCount !== 16'h0) begin errors++; $display("FAIL single_stall: got %h want 0", bus.StallCount); end
        step();
        checks++; if (bus.ValidOut !== 1'b0) begin errors++; $display("FAIL bubble_valid: got %b want 0", bus.ValidOut); end
        checks++; if (bus.CtrlOut !== '0) begin errors++; $display("FAIL bubble_ctrl: got %h want 0", bus.CtrlOut); end
        checks++; if (bus.DataOut !== 101'd1) begin errors++; $display("FAIL bubble_data_hold: got %h want 1", bus.DataOut); end
        checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL single_count: got %0d want 1", obs_q.size()); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = done_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL single_item: got %h want %h", o, e); end
        end
    endtask

    task automatic test_stream();
        item_t o, e;
        do_reset();
        bus.ReadyIn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(CTRL_W'(i * 13 + 1), rnd_data());
            step();
            checks++; if (bus.ValidOut !== 1'b1) begin errors++; $display("FAIL stream_gap: cycle %0d valid got %b want 1", i, bus.ValidOut); end
        end
        bus.ValidIn = 1'b0;
        step();
        checks++; if (obs_q.size() !== 8) begin errors++; $display("FAIL stream_count: got %0d want 8", obs_q.size()); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = done_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL stream_item: got %h want %h", o, e); end
        end
    endtask

    task automatic test_hold();
        item_t o, e;
        logic [CTRL_W-1:0] ca;
        logic [DATA_W-1:0] da;
        logic b_taken;
        int   guard;
        do_reset();
        ca = 7'h2A;
        da = rnd_data();
        bus.ReadyIn = 1'b0;
        drive(ca, da);
        step();
        drive(7'h13, rnd_data());
        b_taken = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (last_acc) begin b_taken = 1'b1; bus.ValidIn = 1'b0; end
            checks++; if (bus.ValidOut !== 1'b1 || bus.CtrlOut !== ca || bus.DataOut !== da) begin
                errors++; $display("FAIL hold_stable: cycle %0d got v=%b c=%h d=%h want v=1 c=%h d=%h", k, bus.ValidOut, bus.CtrlOut, bus.DataOut, ca, da);
            end
        end
        checks++; if (bus.StallCount !== 16'd5) begin errors++; $display("FAIL hold_stall_count: got %0d want 5", bus.StallCount); end
        checks++; if (bus.ReadyOut !== 1'b0) begin errors++; $display("FAIL hold_ready: got %b want 0", bus.ReadyOut); end
        checks++; if (b_taken !== EXP_B_IN_SKID) begin errors++; $display("FAIL hold_b_accept: got %b want %b", b_taken, EXP_B_IN_SKID); end
        bus.ReadyIn = 1'b1;
        guard = 0;
        while ((bus.ValidOut === 1'b1 || bus.ValidIn === 1'b1) && guard < 10) begin
            step();
            if (last_acc) bus.ValidIn = 1'b0;
            guard++;
        end
        checks++; if (guard >= 10) begin errors++; $display("FAIL hold_release_timeout: got %0d cycles want <10", guard); end
        checks++; if (obs_q.size() !== 2) begin errors++; $display("FAIL hold_count: got %0d want 2", obs_q.size()); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = done_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL hold_order: got %h want %h", o, e); end
        end
    endtask

    task automatic test_flush();
        item_t o, e;
        logic [DATA_W-1:0] dd;
        do_reset();
        dd = rnd_data();
        bus.ReadyIn = 1'b0;
        drive(7'h11, dd);
        step();
        bus.ReadyIn = 1'b1;
        bus.Flush   = 1'b1;
        drive(7'h7F, rnd_data());
        step();
        bus.Flush   = 1'b0;
        bus.ValidIn = 1'b0;
        checks++; if (bus.ValidOut !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", bus.ValidOut); end
        checks++; if (bus.CtrlOut !== '0) begin errors++; $display("FAIL flush_ctrl: got %h want 0", bus.CtrlOut); end
        checks++; if (bus.DataOut !== dd) begin errors++; $display("FAIL flush_data_hold: got %h want %h", bus.DataOut, dd); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (bus.ValidOut !== 1'b0) begin errors++; $display("FAIL flush_item_appeared: cycle %0d valid got %b want 0", k, bus.ValidOut); end
        end
        checks++; if (obs_q.size() !== 1) begin errors++; $display("FAIL flush_count: got %0d want 1", obs_q.size()); end
        while (obs_q.size() > 0) begin
            o = obs_q.pop_front(); e = done_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL flush_item: got %h want %h", o, e); end
        end
        // Flush of a stalled item: killed, and that cycle does not count as a stall.
        bus.ReadyIn = 1'b0;
        drive(7'h22, rnd_data());
        step();
        bus.ValidIn = 1'b0;
        bus.Flush   = 1'b1;
        step();
        bus.Flush = 1'b0;
        checks++; if (bus.ValidOut !== 1'b0) begin errors++; $display("FAIL flush_held_valid: got %b want 0", bus.ValidOut); end
        checks++; if (bus.StallCount !== 16'd0) begin errors++; $display("FAIL flush_stall_count: got %0d want 0", bus.StallCount); end
    endtask

    task automatic test_saturate();
        do_reset();
        bus.ReadyIn = 1'b0;
        drive(7'h3C, rnd_data());
        step();
        bus.ValidIn = 1'b0;
        for (int k = 0; k < 65534; k++) step();
        checks++; if (bus.StallCount !== 16'hFFFE) begin errors++; $display("FAIL stall_near_sat: got %h want fffe", bus.StallCount); end
        for (int k = 0; k < 70000 - 65534; k++) step();
        checks++; if (bus.StallCount !== 16'hFFFF) begin errors++; $display("FAIL stall_saturated: got %h want ffff", bus.StallCount); end
        checks++; if (bus.ValidOut !== 1'b1) begin errors++; $display("FAIL stall_still_valid: got %b want 1", bus.ValidOut); end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (bus.ValidOut !== 1'b0 || bus.CtrlOut !== '0 || bus.DataOut !== '0 || bus.StallCount !== 16'h0) begin
            errors++; $display("FAIL async_reset: got v=%b c=%h d=%h s=%h want all 0", bus.ValidOut, bus.CtrlOut, bus.DataOut, bus.StallCount);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete(); done_q.delete(); obs_q.delete();
        #1;
        checks++; if (bus.ReadyOut !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b want 1", bus.ReadyOut); end
        step();
        checks++; if (bus.ValidOut !== 1'b0) begin errors++; $display("FAIL no_partial_update: got %b want 0", bus.ValidOut); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_hold();
        test_flush();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
